// File: rtl/pwm_pkg.sv
// Shared definitions for the RGBW PWM frame sequencer.
//   DEF_NCH/DEF_DW/DEF_PW : default channel count, duty/counter width, prescaler width
//   pwmState_e             : sequencer FSM states
//   CH_R..CH_W             : channel index constants
//   chIdxWidth()           : width of a channel index for a given channel count
package pwm_pkg;

   localparam int unsigned DEF_NCH = 4;
   localparam int unsigned DEF_DW  = 8;
   localparam int unsigned DEF_PW  = 8;

   localparam int unsigned CH_R = 0;
   localparam int unsigned CH_G = 1;
   localparam int unsigned CH_B = 2;
   localparam int unsigned CH_W = 3;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StDrain = 2'b10
   } pwmState_e;

   // A single channel still needs a 1-bit index port.
   function automatic int unsigned chIdxWidth(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_frame_sequencer_if.sv
// Duty-write / commit bus between the command front end and the PWM sequencer.
//   wr_valid, wr_ch, wr_duty : single-cycle shadow duty write
//   commit                   : request shadow->active transfer at the next boundary
//   commit_pending           : transfer requested but not yet done
//   commit_ack               : one-cycle pulse after the transfer
// master = front end, slave = sequencer.
interface pwm_frame_sequencer_if #(
   parameter int unsigned NCH = pwm_pkg::DEF_NCH,
   parameter int unsigned DW  = pwm_pkg::DEF_DW
);
   localparam int unsigned CHW = pwm_pkg::chIdxWidth(NCH);

   logic           wr_valid;
   logic [CHW-1:0] wr_ch;
   logic [DW-1:0]  wr_duty;
   logic           commit;
   logic           commit_pending;
   logic           commit_ack;

   modport master (
      output wr_valid, wr_ch, wr_duty, commit,
      input  commit_pending, commit_ack
   );

   modport slave (
      input  wr_valid, wr_ch, wr_duty, commit,
      output commit_pending, commit_ack
   );

endinterface

// File: rtl/pwm_tick_gen.sv
// Prescaler producing the PWM tick as a clock enable.
//   clk, reset : system clock, async active-low reset
//   run        : count only while high; counter held at 0 otherwise
//   prescAct   : active divider; one tick every prescAct+1 cycles
//   tick       : combinational enable, high on the last cycle of each divide interval
module pwm_tick_gen
   import pwm_pkg::*;
#(
   parameter int unsigned PW = DEF_PW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic [PW-1:0] prescAct,
   output logic          tick
);

   logic [PW-1:0] cnt;

   assign tick = run && (cnt == prescAct);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!run || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_frame_sequencer.sv
// RGBW PWM frame sequencer: shared period counter, double-buffered duties and
// boundary-safe commit sequencing.
//   clk, reset   : system clock, async active-low reset
//   enable       : run when high; when low finish the current period then stop
//   presc        : tick divider, captured only when active duties are loaded
//   cmd          : duty write / commit bus (slave side)
//   period_start : one-cycle pulse at the start of each running period
//   running      : high while the period counter is live (RUN or DRAIN)
//   pwm_out      : registered per-channel PWM outputs
module pwm_frame_sequencer
   import pwm_pkg::*;
#(
   parameter int unsigned NCH = DEF_NCH,
   parameter int unsigned DW  = DEF_DW,
   parameter int unsigned PW  = DEF_PW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [PW-1:0]         presc,
   pwm_frame_sequencer_if.slave  cmd,
   output logic                  period_start,
   output logic                  running,
   output logic [NCH-1:0]        pwm_out
);

   pwmState_e      state;
   pwmState_e      stateNext;
   logic           run;
   logic           tick;
   logic           boundary;
   logic           load;

   logic [PW-1:0]  prescAct;
   logic [DW-1:0]  pwmCnt;
   logic [DW-1:0]  shadow  [NCH];
   logic [DW-1:0]  dutyAct [NCH];
   logic           pendingQ;
   logic           ackQ;
   logic           periodStartQ;
   logic [NCH-1:0] pwmOutQ;

   assign run = (state != StIdle);

   pwm_tick_gen #(
      .PW (PW)
   ) u_tickGen (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .prescAct (prescAct),
      .tick     (tick)
   );

   // Last tick of a period: the counter is about to wrap to 0.
   assign boundary = tick && (pwmCnt == {DW{1'b1}});

   always_comb begin
      stateNext = state;
      load      = 1'b0;
      case (state)
         StIdle: begin
            if (enable) begin
               stateNext = StRun;
               load      = 1'b1;
            end
         end
         StRun: begin
            if (boundary && pendingQ) begin
               load = 1'b1;
            end
            if (!enable) begin
               stateNext = StDrain;
            end
         end
         StDrain: begin
            // Re-enable wins so the pattern continues without a restart.
            if (enable) begin
               stateNext = StRun;
            end else if (boundary) begin
               stateNext = StIdle;
            end
         end
         default: stateNext = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= StIdle;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwmCnt <= '0;
      end else if (!run) begin
         pwmCnt <= '0;
      end else if (tick) begin
         pwmCnt <= pwmCnt + 1'b1;
      end
   end

   // The load reads the pre-write shadow; a same-cycle write lands in shadow only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            dutyAct[i] <= '0;
         end
         prescAct <= '0;
      end else if (load) begin
         dutyAct  <= shadow;
         prescAct <= presc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            shadow[i] <= '0;
         end
      end else if (cmd.wr_valid && (32'(cmd.wr_ch) < NCH)) begin
         shadow[cmd.wr_ch] <= cmd.wr_duty;
      end
   end

   // A commit arriving on the load cycle re-arms pending for the next boundary.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pendingQ     <= 1'b0;
         ackQ         <= 1'b0;
         periodStartQ <= 1'b0;
      end else begin
         pendingQ     <= (pendingQ && !load) || cmd.commit;
         ackQ         <= load && pendingQ;
         periodStartQ <= ((state == StIdle) && enable) || (boundary && (stateNext != StIdle));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwmOutQ <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            pwmOutQ[i] <= run && (pwmCnt < dutyAct[i]);
         end
      end
   end

   assign cmd.commit_pending = pendingQ;
   assign cmd.commit_ack     = ackQ;
   assign period_start       = periodStartQ;
   assign running            = run;
   assign pwm_out            = pwmOutQ;

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
module tb_pwm_frame_sequencer;
   import pwm_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] presc = '0;
   logic       period_start;
   logic       running;
   logic [3:0] pwm_out;

   pwm_frame_sequencer_if cmd ();

   pwm_frame_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .presc        (presc),
      .cmd          (cmd),
      .period_start (period_start),
      .running      (running),
      .pwm_out      (pwm_out)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nPass = 0;

   // Reference model: time within the period is kept as a raw clock count,
   // the tick index is derived from it by division.
   int       mMode;   // 0 idle, 1 run, 2 drain
   int       mPos;    // clk cycles since the current period started
   int       mPresc;
   int       mDuty [4];
   int       mShadow [4];
   bit       mPend, mAck, mPs;
   bit [3:0] mOut;

   logic       enCur = 1'b0;
   logic [7:0] prescCur = '0;
   logic [7:0] obs;
   int hiCnt [4];
   int psCnt, ackCnt, pendCnt, runLowCnt;

   typedef struct {
      logic       en;
      logic       wv;
      logic [1:0] wc;
      logic [7:0] wd;
      logic       cm;
      logic [7:0] exp;   // {running, pending, ack, period_start, pwm_out[3:0]}
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic model_reset();
      mMode = 0; mPos = 0; mPresc = 0; mPend = 0; mAck = 0; mPs = 0; mOut = '0;
      for (int i = 0; i < 4; i++) begin
         mDuty[i] = 0;
         mShadow[i] = 0;
      end
   endtask

   task automatic model_step(input bit en, input bit wv, input int wc, input int wd,
                             input bit cm, input int pr);
      int div, len, phase, nMode;
      bit run, bnd, load;
      div   = mPresc + 1;
      len   = 256 * div;
      run   = (mMode != 0);
      phase = mPos / div;
      bnd   = run && (mPos == len - 1);
      for (int i = 0; i < 4; i++) mOut[i] = run && (phase < mDuty[i]);
      load  = 0;
      nMode = mMode;
      if (mMode == 0) begin
         if (en) begin nMode = 1; load = 1; end
      end else if (mMode == 1) begin
         if (bnd && mPend) load = 1;
         if (!en) nMode = 2;
      end else begin
         if (en) nMode = 1;
         else if (bnd) nMode = 0;
      end
      mAck  = load && mPend;
      mPs   = (mMode == 0 && en) || (bnd && nMode != 0);
      mPend = (mPend && !load) || cm;
      if (!run || bnd) mPos = 0;
      else mPos++;
      if (load) begin
         for (int i = 0; i < 4; i++) mDuty[i] = mShadow[i];
         mPresc = pr;
      end
      if (wv && wc < 4) mShadow[wc] = wd;
      mMode = nMode;
   endtask

   task automatic clr_counts();
      for (int i = 0; i < 4; i++) hiCnt[i] = 0;
      psCnt = 0; ackCnt = 0; pendCnt = 0; runLowCnt = 0;
   endtask

   // Called at a negedge: drive inputs, advance the model, cross one posedge, compare.
   task automatic step(input logic en, input logic wv, input logic [1:0] wc,
                       input logic [7:0] wd, input logic cm);
      enable       = en;
      presc        = prescCur;
      cmd.wr_valid = wv;
      cmd.wr_ch    = wc;
      cmd.wr_duty  = wd;
      cmd.commit   = cm;
      model_step(en, wv, int'(wc), int'(wd), cm, int'(prescCur));
      @(posedge clk);
      @(negedge clk);
      obs = {running, cmd.commit_pending, cmd.commit_ack, period_start, pwm_out};
      check("model", 32'(obs), 32'({mMode != 0, mPend, mAck, mPs, mOut}));
      for (int i = 0; i < 4; i++) hiCnt[i] += int'(pwm_out[i]);
      psCnt     += int'(period_start);
      ackCnt    += int'(cmd.commit_ack);
      pendCnt   += int'(cmd.commit_pending);
      runLowCnt += int'(!running);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(enCur, 1'b0, 2'd0, 8'd0, 1'b0);
   endtask

   task automatic wr(input int ch, input int val);
      step(enCur, 1'b1, 2'(ch), 8'(val), 1'b0);
   endtask

   task automatic wait_ack(input int maxN, input string name);
      bit seen = 0;
      for (int i = 0; i < maxN && !seen; i++) begin
         step(enCur, 1'b0, 2'd0, 8'd0, 1'b0);
         seen = cmd.commit_ack;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   initial begin
      model_reset();
      clr_counts();
      cmd.wr_valid = 1'b0;
      cmd.wr_ch    = '0;
      cmd.wr_duty  = '0;
      cmd.commit   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_state", 32'({running, cmd.commit_pending, cmd.commit_ack, period_start,
                                pwm_out}), 32'd0);
      reset = 1'b1;

      // Table: write ch0/ch3 and commit while idle, then enable.
      vecs[0] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 8'b0000_0000};
      vecs[1] = '{1'b0, 1'b1, 2'd0, 8'd64,  1'b0, 8'b0000_0000};
      vecs[2] = '{1'b0, 1'b1, 2'd3, 8'd255, 1'b0, 8'b0000_0000};
      vecs[3] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b1, 8'b0100_0000};
      vecs[4] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 8'b0100_0000};
      vecs[5] = '{1'b1, 1'b0, 2'd0, 8'd0,   1'b0, 8'b1011_0000};
      vecs[6] = '{1'b1, 1'b0, 2'd0, 8'd0,   1'b0, 8'b1000_1001};
      vecs[7] = '{1'b1, 1'b0, 2'd0, 8'd0,   1'b0, 8'b1000_1001};
      for (int i = 0; i < 8; i++) begin
         step(vecs[i].en, vecs[i].wv, vecs[i].wc, vecs[i].wd, vecs[i].cm);
         check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
      end
      enCur = 1'b1;

      // Duty 64 / 255 over two full periods; untouched channels stay low.
      clr_counts();
      idle(256);
      check("duty64_p1", 32'(hiCnt[CH_R]), 32'd64);
      check("duty255_p1", 32'(hiCnt[CH_W]), 32'd255);
      check("pstart_p1", 32'(psCnt), 32'd1);
      idle(256);
      check("duty64_p2", 32'(hiCnt[CH_R]), 32'd128);
      check("duty0_512", 32'(hiCnt[CH_G] + hiCnt[CH_B]), 32'd0);
      check("pstart_p2", 32'(psCnt), 32'd2);

      // Mid-period commit: ch1 keeps 100 until the boundary, then 200.
      wr(CH_G, 100);
      step(enCur, 1'b0, 2'd0, 8'd0, 1'b1);
      wait_ack(300, "ack_ch1_100");
      clr_counts();
      idle(256);
      check("duty100", 32'(hiCnt[CH_G]), 32'd100);
      wr(CH_G, 200);
      step(enCur, 1'b0, 2'd0, 8'd0, 1'b1);
      clr_counts();
      wait_ack(300, "ack_ch1_200");
      check("pending_until_bnd", 32'(pendCnt), 32'd253);
      check("old_duty_kept", 32'(hiCnt[CH_G]), 32'd98);
      check("ack_once", 32'(ackCnt), 32'd1);
      clr_counts();
      idle(256);
      check("duty200", 32'(hiCnt[CH_G]), 32'd200);

      // presc=3 via commit: 1024-cycle period.
      prescCur = 8'd3;
      step(enCur, 1'b0, 2'd0, 8'd0, 1'b1);
      wait_ack(300, "ack_presc3");
      clr_counts();
      idle(1024);
      check("presc3_pstart", 32'(psCnt), 32'd1);
      check("presc3_duty200", 32'(hiCnt[CH_G]), 32'd800);

      // Back to presc=0; drain at count 10, re-enable at 50: pattern continuous.
      prescCur = 8'd0;
      step(enCur, 1'b0, 2'd0, 8'd0, 1'b1);
      wait_ack(1100, "ack_presc0");
      idle(9);
      clr_counts();
      enCur = 1'b0;
      idle(40);
      enCur = 1'b1;
      idle(216);
      check("drain_cont_duty", 32'(hiCnt[CH_G]), 32'd200);
      check("drain_cont_pstart", 32'(psCnt), 32'd1);
      check("drain_no_stop", 32'(runLowCnt), 32'd0);

      // Hold enable low: back to idle at the boundary, outputs low.
      enCur = 1'b0;
      begin
         bit stopped = 0;
         for (int i = 0; i < 300 && !stopped; i++) begin
            idle(1);
            stopped = !running;
         end
         check("drain_to_idle", 32'(stopped), 32'd1);
      end
      check("idle_pwm_low", 32'(pwm_out), 32'd0);
      clr_counts();
      idle(5);
      check("idle_quiet", 32'(hiCnt[0] + hiCnt[1] + hiCnt[2] + hiCnt[3] + psCnt), 32'd0);

      // Enable with a same-cycle write to ch0 (load takes old 64); commit on the boundary.
      enCur = 1'b1;
      step(enCur, 1'b1, 2'(CH_R), 8'd5, 1'b0);
      clr_counts();
      idle(9);
      wr(CH_B, 77);
      idle(245);
      step(enCur, 1'b0, 2'd0, 8'd0, 1'b1);
      check("load_pre_write", 32'(hiCnt[CH_R]), 32'd64);
      clr_counts();
      idle(255);
      check("bnd_commit_deferred", 32'(ackCnt), 32'd0);
      idle(1);
      check("bnd_commit_next", 32'(ackCnt), 32'd1);
      clr_counts();
      idle(256);
      check("wr_after_commit", 32'(hiCnt[CH_R]), 32'd5);
      check("ch2_applied", 32'(hiCnt[CH_B]), 32'd77);

      // Reset mid-run: outputs drop immediately.
      idle(2);
      check("pre_reset_high", 32'(pwm_out[CH_W]), 32'd1);
      reset = 1'b0;
      #1;
      check("reset_async", 32'({running, cmd.commit_pending, cmd.commit_ack, period_start,
                                pwm_out}), 32'd0);
      model_reset();
      enCur = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // All duties zero after reset: no output, period_start every 256.
      enCur = 1'b1;
      idle(1);
      clr_counts();
      idle(512);
      check("zero_duty_low", 32'(hiCnt[0] + hiCnt[1] + hiCnt[2] + hiCnt[3]), 32'd0);
      check("zero_duty_pstart", 32'(psCnt), 32'd2);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(199) == 0) enCur = ~enCur;
         prescCur = 8'($urandom_range(2));
         step(enCur, 1'($urandom_range(7) == 0), 2'($urandom_range(3)), 8'($urandom),
              1'($urandom_range(99) == 0));
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
